sram_stream_loader: RTL and testbench

// Upstream feeder for the accelerator's feature/kernel SRAM BRAM-ctrl port (byte-indexed addr, word data).

---
 rtl/sram_stream_loader.sv | 158 +++++++++++++++
 tb/tb_sram_stream_loader.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_stream_loader.sv
// sram_stream_loader
// Feeds one accelerator SRAM (feature or kernel) from an AXI4-Stream of words.
// A cfg_start pulse latches a byte base address and a word count; accepted
// stream beats are then written to consecutive word addresses with a single
// registered write stage. Starts that would overrun the SRAM, are misaligned or
// collide with a running conv engine are refused and flagged through err.

module sram_stream_loader #(
  parameter int DATA_WIDTH      = 32,
  parameter int BYTE_ADDR_WIDTH = 14,
  parameter int LEN_WIDTH       = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       cfg_start,
  input  logic [BYTE_ADDR_WIDTH-1:0] cfg_baseaddr,
  input  logic [LEN_WIDTH-1:0]       cfg_len,
  input  logic                       acc_running,
  input  logic [DATA_WIDTH-1:0]      s_axis_tdata,
  input  logic                       s_axis_tvalid,
  input  logic                       s_axis_tlast,
  output logic                       s_axis_tready,
  output logic [BYTE_ADDR_WIDTH-1:0] bram_addr_byteidx,
  output logic [DATA_WIDTH-1:0]      bram_wdata,
  output logic                       bram_we,
  output logic                       bram_en,
  output logic                       busy,
  output logic                       done,
  output logic                       err
);

  // Range check width: base + 4*len must never wrap before the comparison.
  localparam int WIDE_W = BYTE_ADDR_WIDTH + LEN_WIDTH + 2;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]                 state;
  logic [1:0]                 state_nxt;
  logic [BYTE_ADDR_WIDTH-1:0] base_q;
  logic [LEN_WIDTH-1:0]       remaining;
  logic [LEN_WIDTH-1:0]       idx;
  // Set once the final (or early-tlast) beat has been taken; the FSM waits one
  // more cycle so the registered write of that beat is issued before DONE.
  logic                       term;

  logic [WIDE_W-1:0]          end_addr;
  logic [WIDE_W-1:0]          addr_limit;
  logic                       start_bad;
  logic                       start_ok;
  logic                       start_rej;
  logic                       beat;
  logic                       last_beat;
  logic                       early_last;
  logic                       missing_last;
  logic                       abort;

  logic                       wr_vld_p1;
  logic [BYTE_ADDR_WIDTH-1:0] wr_addr_p1;
  logic [DATA_WIDTH-1:0]      wr_data_p1;

  assign end_addr   = WIDE_W'(cfg_baseaddr) + (WIDE_W'(cfg_len) << 2);
  assign addr_limit = WIDE_W'(1) << BYTE_ADDR_WIDTH;

  assign start_bad  = acc_running
                    | (cfg_baseaddr[1:0] != 2'b00)
                    | (end_addr > addr_limit);
  assign start_ok   = (state == IDLE) & cfg_start & ~start_bad;
  assign start_rej  = (state == IDLE) & cfg_start &  start_bad;

  // Ready is withdrawn combinationally the moment the conv engine starts, so
  // no beat can slip in on the abort cycle.
  assign s_axis_tready = (state == RUN) & ~term & (remaining != '0) & ~acc_running;

  assign beat         = s_axis_tvalid & s_axis_tready;
  assign last_beat    = beat & (remaining == LEN_WIDTH'(1));
  assign early_last   = beat & s_axis_tlast & (remaining > LEN_WIDTH'(1));
  assign missing_last = last_beat & ~s_axis_tlast;
  assign abort        = (state == RUN) & ~term & acc_running;

  // Next-state selection for the IDLE/RUN/DONE sequencer.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start_ok) begin
          state_nxt = (cfg_len == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (term || abort) begin
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Control state: FSM, transfer counters, done pulse and sticky error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      base_q    <= '0;
      remaining <= '0;
      idx       <= '0;
      term      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state <= state_nxt;
      // A refused start still owes the requester a completion pulse.
      done  <= (state_nxt == DONE) | start_rej;

      if (start_ok) begin
        base_q    <= cfg_baseaddr;
        remaining <= cfg_len;
        idx       <= '0;
        term      <= 1'b0;
      end else if (beat) begin
        remaining <= remaining - LEN_WIDTH'(1);
        idx       <= idx + LEN_WIDTH'(1);
        if (last_beat || early_last) begin
          term <= 1'b1;
        end
      end

      if (start_ok) begin
        err <= 1'b0;
      end else if (start_rej || early_last || missing_last || abort) begin
        err <= 1'b1;
      end
    end
  end

  // Write stage: one registered SRAM write per accepted beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_vld_p1  <= 1'b0;
      wr_addr_p1 <= '0;
      wr_data_p1 <= '0;
    end else begin
      wr_vld_p1 <= beat;
      if (beat) begin
        wr_addr_p1 <= base_q + BYTE_ADDR_WIDTH'({idx, 2'b00});
        wr_data_p1 <= s_axis_tdata;
      end
    end
  end

  assign bram_we           = wr_vld_p1;
  assign bram_en           = wr_vld_p1;
  assign bram_addr_byteidx = wr_addr_p1;
  assign bram_wdata        = wr_data_p1;
  assign busy              = (state != IDLE);

endmodule

// File: tb/tb_sram_stream_loader.sv
// Self-checking bench for sram_stream_loader: directed scenarios plus random
// transfers, each compared against an expected write list derived from the
// base/length/tlast/abort rules of the loader.

module tb_sram_stream_loader;

  localparam int DW = 32;
  localparam int AW = 14;
  localparam int LW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cfg_start = 1'b0;
  logic [AW-1:0] cfg_baseaddr = '0;
  logic [LW-1:0] cfg_len = '0;
  logic          acc_running = 1'b0;
  logic [DW-1:0] s_axis_tdata = '0;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tlast = 1'b0;
  logic          s_axis_tready;
  logic [AW-1:0] bram_addr_byteidx;
  logic [DW-1:0] bram_wdata;
  logic          bram_we;
  logic          bram_en;
  logic          busy;
  logic          done;
  logic          err;

  sram_stream_loader #(
    .DATA_WIDTH      (DW),
    .BYTE_ADDR_WIDTH (AW),
    .LEN_WIDTH       (LW)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .cfg_start         (cfg_start),
    .cfg_baseaddr      (cfg_baseaddr),
    .cfg_len           (cfg_len),
    .acc_running       (acc_running),
    .s_axis_tdata      (s_axis_tdata),
    .s_axis_tvalid     (s_axis_tvalid),
    .s_axis_tlast      (s_axis_tlast),
    .s_axis_tready     (s_axis_tready),
    .bram_addr_byteidx (bram_addr_byteidx),
    .bram_wdata        (bram_wdata),
    .bram_we           (bram_we),
    .bram_en           (bram_en),
    .busy              (busy),
    .done              (done),
    .err               (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  // Observation queues filled at the falling edge
  bit            mon_on = 1'b0;
  logic [AW-1:0] wr_addr[$];
  logic [DW-1:0] wr_data[$];
  int            wr_cyc[$];
  int            acc_cyc[$];
  int            done_cnt;
  int            done_cyc;
  int            en_bad;
  logic [DW-1:0] words[$];

  always @(negedge clk) begin
    if (mon_on) begin
      if (bram_we) begin
        wr_addr.push_back(bram_addr_byteidx);
        wr_data.push_back(bram_wdata);
        wr_cyc.push_back(cyc);
      end
      if (bram_en !== bram_we) en_bad++;
      if (s_axis_tvalid && s_axis_tready) acc_cyc.push_back(cyc);
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clear_mon();
    wr_addr.delete();
    wr_data.delete();
    wr_cyc.delete();
    acc_cyc.delete();
    done_cnt = 0;
    done_cyc = -1;
    en_bad   = 0;
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_tready"}, s_axis_tready, 0);
    chk({name, "_we"}, bram_we, 0);
    chk({name, "_en"}, bram_en, 0);
    chk({name, "_addr"}, bram_addr_byteidx, 0);
    chk({name, "_wdata"}, bram_wdata, 0);
    chk({name, "_busy"}, busy, 0);
    chk({name, "_done"}, done, 0);
    chk({name, "_err"}, err, 0);
  endtask

  // One complete transfer: program, stream, then compare with the model.
  //   tlast_at : beat index carrying tlast (outside 0..nbeats-1 means none)
  //   vmode    : 0 continuous valid, 1 alternating 1,0,1,0, 2 random
  //   abort_at : raise acc_running once this many beats are taken (-1 never)
  task automatic run_txn(input string name, input int base, input int len,
                         input int nbeats, input int tlast_at, input int vmode,
                         input int abort_at, input bit acc_at_start,
                         input bit poke_start);
    int  k;
    int  budget;
    int  start_cyc;
    int  n_exp;
    bit  rej;
    bit  aborted;
    bit  exp_err;
    bit  acc;
    bit  poked;

    words.delete();
    for (int i = 0; i < nbeats; i++) words.push_back($urandom);
    clear_mon();

    @(posedge clk); #1;
    mon_on       = 1'b1;
    acc_running  = acc_at_start;
    cfg_baseaddr = base[AW-1:0];
    cfg_len      = len[LW-1:0];
    cfg_start    = 1'b1;
    @(negedge clk);
    start_cyc = cyc;
    @(posedge clk); #1;
    cfg_start    = 1'b0;
    cfg_baseaddr = AW'($urandom);
    cfg_len      = LW'($urandom);
    acc_running  = 1'b0;

    k = 0;
    budget = 0;
    poked = 1'b0;
    while (done_cnt == 0 && budget < 300) begin
      s_axis_tvalid = (k < nbeats) &&
                      ((vmode == 0) || (vmode == 1 && (budget % 2) == 0) ||
                       (vmode == 2 && $urandom_range(0, 1) == 1));
      s_axis_tdata  = (k < nbeats) ? words[k] : $urandom;
      s_axis_tlast  = (k == tlast_at);
      if (abort_at >= 0 && k >= abort_at) acc_running = 1'b1;
      if (poke_start && k >= 1 && !poked) begin
        cfg_start    = 1'b1;
        cfg_baseaddr = AW'($urandom_range(0, 15) * 4);
        cfg_len      = LW'(2);
        poked        = 1'b1;
      end else begin
        cfg_start = 1'b0;
      end
      @(negedge clk);
      acc = s_axis_tvalid && s_axis_tready;
      @(posedge clk); #1;
      if (acc) k++;
      budget++;
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    cfg_start     = 1'b0;
    acc_running   = 1'b0;
    if (budget >= 300) chk({name, "_timeout"}, 1, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    mon_on = 1'b0;

    // Expected outcome from the transfer rules
    rej     = acc_at_start || (base % 4 != 0) || (base + 4 * len > (1 << AW));
    aborted = 1'b0;
    if (rej) begin
      n_exp   = 0;
      exp_err = 1'b1;
    end else if (len == 0) begin
      n_exp   = 0;
      exp_err = 1'b0;
    end else begin
      n_exp = (tlast_at >= 0 && tlast_at < len) ? tlast_at + 1 : len;
      if (abort_at >= 0 && abort_at < n_exp) begin
        n_exp   = abort_at;
        aborted = 1'b1;
      end
      exp_err = aborted || (tlast_at != len - 1);
    end

    chk({name, "_nwr"}, wr_addr.size(), n_exp);
    chk({name, "_nacc"}, acc_cyc.size(), n_exp);
    for (int j = 0; j < n_exp && j < wr_addr.size(); j++) begin
      chk($sformatf("%s_addr%0d", name, j), wr_addr[j], base + 4 * j);
      chk($sformatf("%s_data%0d", name, j), wr_data[j], words[j]);
      if (j < acc_cyc.size())
        chk($sformatf("%s_lat%0d", name, j), wr_cyc[j], acc_cyc[j] + 1);
      if (vmode == 0)
        chk($sformatf("%s_b2b%0d", name, j), wr_cyc[j], wr_cyc[0] + j);
    end
    chk({name, "_done_cnt"}, done_cnt, 1);
    chk({name, "_err"}, err, exp_err);
    chk({name, "_busy_end"}, busy, 0);
    chk({name, "_en_eq_we"}, en_bad, 0);
    if (rej || len == 0)
      chk({name, "_done_t"}, done_cyc, start_cyc + 1);
    else if (!aborted && wr_cyc.size() > 0)
      chk({name, "_done_t"}, done_cyc, wr_cyc[wr_cyc.size() - 1] + 1);
  endtask

  // Reset after 2 of 6 beats: outputs clear, then a fresh 2-word load works.
  task automatic reset_test();
    int k;
    int budget;
    bit acc;

    words.delete();
    for (int i = 0; i < 6; i++) words.push_back($urandom);
    clear_mon();
    @(posedge clk); #1;
    mon_on       = 1'b1;
    cfg_baseaddr = AW'(14'h100);
    cfg_len      = LW'(6);
    cfg_start    = 1'b1;
    @(posedge clk); #1;
    cfg_start = 1'b0;
    k = 0;
    budget = 0;
    while (k < 2 && budget < 50) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = words[k];
      s_axis_tlast  = 1'b0;
      @(negedge clk);
      acc = s_axis_tvalid && s_axis_tready;
      @(posedge clk); #1;
      if (acc) k++;
      budget++;
    end
    s_axis_tvalid = 1'b0;
    if (budget >= 50) chk("rst_timeout", 1, 0);
    @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    mon_on = 1'b0;
    chk_all_zero("rst_mid");
    chk("rst_mid_nwr", wr_addr.size(), 2);
    for (int j = 0; j < 2 && j < wr_addr.size(); j++) begin
      chk($sformatf("rst_mid_addr%0d", j), wr_addr[j], 32'h100 + 4 * j);
      chk($sformatf("rst_mid_data%0d", j), wr_data[j], words[j]);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_txn("after_rst", 32'h200, 2, 2, 1, 0, -1, 1'b0, 1'b0);
  endtask

  initial begin
    int base;
    int len;
    int tl;
    int r;

    rst_n = 1'b0;
    @(negedge clk);
    chk_all_zero("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Back-to-back 4-word load
    run_txn("b2b", 32'h040, 4, 4, 3, 0, -1, 1'b0, 1'b0);
    // Same load with valid toggling
    run_txn("toggle", 32'h040, 4, 4, 3, 1, -1, 1'b0, 1'b0);
    // Early tlast on the third beat of eight
    run_txn("early", 32'h000, 8, 8, 2, 0, -1, 1'b0, 1'b0);
    // Rejections
    run_txn("rej_acc", 32'h000, 4, 4, 3, 0, -1, 1'b1, 1'b0);
    // err still set from the refusal; a zero-length start clears it
    run_txn("len0", 32'h080, 0, 2, -1, 0, -1, 1'b0, 1'b0);
    run_txn("rej_align", 32'h002, 4, 4, 3, 0, -1, 1'b0, 1'b0);
    run_txn("rej_range", 32'h3FF0, 8, 8, 7, 0, -1, 1'b0, 1'b0);
    // Exactly filling the top of the SRAM is legal
    run_txn("top_fit", 32'h3FE0, 8, 8, 7, 0, -1, 1'b0, 1'b0);
    // Missing tlast with surplus beats offered
    run_txn("no_last", 32'h100, 5, 7, -1, 0, -1, 1'b0, 1'b0);
    // Conv engine starts mid-transfer
    run_txn("abort", 32'h200, 8, 8, 7, 0, 3, 1'b0, 1'b0);
    // Stray start pulse mid-transfer must be ignored
    run_txn("poke", 32'h300, 6, 6, 5, 2, -1, 1'b0, 1'b1);

    reset_test();

    for (int it = 0; it < 16; it++) begin
      len = $urandom_range(0, 12);
      if ($urandom_range(0, 5) == 0)
        base = $urandom_range(0, (1 << AW) - 1);
      else
        base = $urandom_range(0, ((1 << AW) - 4 * len) / 4) * 4;
      r = $urandom_range(0, 3);
      if (r == 2 && len > 1)      tl = $urandom_range(0, len - 2);
      else if (r == 3)            tl = -1;
      else                        tl = len - 1;
      run_txn($sformatf("rnd%0d", it), base, len, len + 2, tl,
              $urandom_range(0, 2), -1, 1'b0, (len >= 4) && ($urandom_range(0, 1) == 1));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
